// File: rtl/rom_rd_pkg.sv
// Shared constants and types for the ROM stream reader.
//   ROM_AW / ROM_DW / ROM_DEPTH : geometry of the 16x16 one-hot lookup ROM
//   rd_state_t                  : reader sequencer states
package rom_rd_pkg;
    localparam int ROM_AW    = 4;
    localparam int ROM_DW    = 16;
    localparam int ROM_DEPTH = 2 ** ROM_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } rd_state_t;
endpackage

// File: rtl/ROM_16x16.sv
// 16x16 one-hot lookup ROM: word at address a has only bit a set.
// Ports:
//   addr : in  ROM_AW  read address
//   data : out ROM_DW  combinational read data
module ROM_16x16
    import rom_rd_pkg::*;
(
    input  logic [ROM_AW-1:0] addr,
    output logic [ROM_DW-1:0] data
);
    always_comb begin
        data = '0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            if (addr == ROM_AW'(i)) data[i] = 1'b1;
        end
    end
endmodule

// File: rtl/onehot_check.sv
// Combinational one-hot detector: is_onehot is 1 when exactly one bit of
// data is set.
// Ports:
//   data      : in  DW  word under test
//   is_onehot : out 1   exactly-one-bit-set flag
module onehot_check #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] data,
    output logic          is_onehot
);
    // Clearing the lowest set bit leaves zero only for a power of two.
    assign is_onehot = (data != '0) && ((data & (data - DW'(1))) == '0);
endmodule

// File: rtl/rom_stream_reader.sv
// Walks an address window of the one-hot lookup ROM (start..end, wrapping
// past the top address), registers each returned word and presents it on a
// valid/ready stream with its address tag and a last-word flag.
// Optional build macro ROM_ONEHOT_CHECK_EN adds a sticky onehot_err output
// that flags any fetched word that is not exactly one-hot.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   start/start_addr/end_addr : window request, sampled only in IDLE
//   abort                   : cancels an operation in FETCH/SEND
//   rom_addr / rom_data     : registered ROM address, combinational ROM data
//   m_data/m_addr/m_valid/m_ready/m_last : output stream
//   busy                    : high whenever not IDLE
//   done                    : one-cycle pulse after last word accepted
//   onehot_err              : (ROM_ONEHOT_CHECK_EN only) sticky data error
module rom_stream_reader
    import rom_rd_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          abort,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] m_data,
    output logic [AW-1:0] m_addr,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
`ifdef ROM_ONEHOT_CHECK_EN
    output logic          onehot_err,
`endif
    output logic          done
);
    rd_state_t     state_q,    state_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [AW-1:0] end_q,      end_d;
    logic [DW-1:0] m_data_q,   m_data_d;
    logic [AW-1:0] m_addr_q,   m_addr_d;
    logic          m_valid_q,  m_valid_d;
    logic          m_last_q,   m_last_d;

`ifdef ROM_ONEHOT_CHECK_EN
    logic onehot_err_q, onehot_err_d;
    logic data_onehot;

    onehot_check #(.DW(DW)) u_onehot_check (
        .data      (rom_data),
        .is_onehot (data_onehot)
    );
`endif

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        end_d      = end_q;
        m_data_d   = m_data_q;
        m_addr_d   = m_addr_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
`ifdef ROM_ONEHOT_CHECK_EN
        onehot_err_d = onehot_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    end_d      = end_addr;
                    rom_addr_d = start_addr;
                    state_d    = FETCH;
`ifdef ROM_ONEHOT_CHECK_EN
                    onehot_err_d = 1'b0;
`endif
                end
            end
            FETCH: begin
                if (abort) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    m_data_d  = rom_data;
                    m_addr_d  = rom_addr_q;
                    m_valid_d = 1'b1;
                    m_last_d  = (rom_addr_q == end_q);
                    state_d   = SEND;
`ifdef ROM_ONEHOT_CHECK_EN
                    if (!data_onehot) onehot_err_d = 1'b1;
`endif
                end
            end
            SEND: begin
                // abort wins over a handshake on the same edge
                if (abort) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = IDLE;
                end else if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + AW'(1);  // wraps at 2**AW
                        state_d    = FETCH;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            end_q      <= '0;
            m_data_q   <= '0;
            m_addr_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
`ifdef ROM_ONEHOT_CHECK_EN
            onehot_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            end_q      <= end_d;
            m_data_q   <= m_data_d;
            m_addr_q   <= m_addr_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
`ifdef ROM_ONEHOT_CHECK_EN
            onehot_err_q <= onehot_err_d;
`endif
        end
    end

    assign rom_addr = rom_addr_q;
    assign m_data   = m_data_q;
    assign m_addr   = m_addr_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
`ifdef ROM_ONEHOT_CHECK_EN
    assign onehot_err = onehot_err_q;
`endif
endmodule
